// File: rtl/tagger_tag_packer.sv
// rtl/tagger_tag_packer.sv - forms time-tag words from converter output and coarse count, buffers them in a FIFO
module tagger_tag_packer #(
    parameter int BITS         = 3,
    parameter int COARSE_BITS  = 24,
    parameter int CONV_LATENCY = 2,
    parameter int FIFO_AW      = 4,
    localparam int TAG_W       = 2 + COARSE_BITS + BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             edge_detected,
    input  logic             raising_edge,
    input  logic [BITS-1:0]  subtimes,
    output logic [TAG_W-1:0] tag_data,
    output logic             tag_valid,
    input  logic             tag_ready,
    output logic [FIFO_AW:0] fifo_level,
    output logic [15:0]      overflow_count
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] TWO_L     = (FIFO_AW + 1)'(2);
    localparam logic [TAG_W-1:0] ROLL_WORD = {2'b10, {(COARSE_BITS + BITS){1'b0}}};

    typedef enum logic {
        ROLL_IDLE,
        ROLL_PENDING
    } roll_state_t;

    roll_state_t state, state_next;

    logic [COARSE_BITS-1:0] counter;
    logic [COARSE_BITS-1:0] dly [CONV_LATENCY];
    logic [COARSE_BITS-1:0] aligned;
    logic [COARSE_BITS-1:0] prev_aligned;
    logic                   wrap;

    logic [TAG_W-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   free;
    logic [FIFO_AW:0]   n_wr;
    logic               pop;
    logic               ev;
    logic [TAG_W-1:0]   ev_word;
    logic               wr0;
    logic               wr1;
    logic [TAG_W-1:0]   wr0_data;
    logic               drop;

    assign aligned = dly[CONV_LATENCY-1];
    // The delay line resets to 0, so reset release never looks like a wrap.
    assign wrap    = (aligned == '0) && (prev_aligned == '1);

    assign tag_valid = (fifo_level != '0);
    assign tag_data  = tag_valid ? mem[rd_ptr] : '0;
    assign pop       = tag_valid && tag_ready;
    assign free      = DEPTH_L - fifo_level + {{FIFO_AW{1'b0}}, pop};
    assign ev        = edge_detected && enable;
    assign ev_word   = {1'b0, raising_edge, aligned, subtimes};
    assign n_wr      = (FIFO_AW + 1)'(wr0) + (FIFO_AW + 1)'(wr1);

    // Free-running coarse counter and its alignment delay line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter      <= '0;
            prev_aligned <= '0;
            for (int i = 0; i < CONV_LATENCY; i++) begin
                dly[i] <= '0;
            end
        end else begin
            counter      <= counter + COARSE_BITS'(1);
            prev_aligned <= aligned;
            dly[0]       <= counter;
            for (int i = 1; i < CONV_LATENCY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    // Pending-rollover state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ROLL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Write arbitration: a due rollover always goes first; events only after it.
    always_comb begin
        state_next = state;
        wr0        = 1'b0;
        wr1        = 1'b0;
        wr0_data   = ev_word;
        drop       = 1'b0;
        if (wrap || state == ROLL_PENDING) begin
            if (free != '0) begin
                wr0        = 1'b1;
                wr0_data   = ROLL_WORD;
                state_next = ROLL_IDLE;
                if (ev) begin
                    if (free >= TWO_L) begin
                        wr1 = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end else begin
                state_next = ROLL_PENDING;
                drop       = ev;
            end
        end else if (ev) begin
            if (free != '0) begin
                wr0 = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // FIFO storage; second write slot carries the event behind a rollover.
    always_ff @(posedge clk) begin
        if (wr0) begin
            mem[wr_ptr] <= wr0_data;
        end
        if (wr1) begin
            mem[wr_ptr + FIFO_AW'(1)] <= ev_word;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            wr_ptr     <= wr_ptr + n_wr[FIFO_AW-1:0];
            rd_ptr     <= rd_ptr + FIFO_AW'(pop);
            fifo_level <= fifo_level + n_wr - (FIFO_AW + 1)'(pop);
        end
    end

    // Saturating count of dropped events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_count <= '0;
        end else if (drop && overflow_count != 16'hFFFF) begin
            overflow_count <= overflow_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_tagger_tag_packer.sv
// tb/tb_tagger_tag_packer.sv - randomized self-checking bench for tagger_tag_packer
module tb_tagger_tag_packer;

    localparam int BITS  = 3;
    localparam int CB    = 8;
    localparam int LAT   = 2;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int TAG_W = 2 + CB + BITS;
    localparam logic [TAG_W-1:0] ROLL = 13'h1000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             edge_detected;
    logic             raising_edge;
    logic [BITS-1:0]  subtimes;
    logic [TAG_W-1:0] tag_data;
    logic             tag_valid;
    logic             tag_ready;
    logic [AW:0]      fifo_level;
    logic [15:0]      overflow_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [TAG_W-1:0] mq[$];
    int               mc;
    bit               mpend;
    int               movf;

    tagger_tag_packer #(
        .BITS(BITS),
        .COARSE_BITS(CB),
        .CONV_LATENCY(LAT),
        .FIFO_AW(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .edge_detected(edge_detected),
        .raising_edge(raising_edge),
        .subtimes(subtimes),
        .tag_data(tag_data),
        .tag_valid(tag_valid),
        .tag_ready(tag_ready),
        .fifo_level(fifo_level),
        .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (model cycle %0d)", name, act, exp, mc);
        end
    endtask

    function automatic logic [TAG_W-1:0] event_word(input int c, input bit pol, input logic [BITS-1:0] sub);
        logic [CB-1:0] stamp;
        stamp = (c >= LAT) ? CB'((c - LAT) % 256) : '0;
        return {1'b0, pol, stamp, sub};
    endfunction

    task automatic model_update();
        bit               roll;
        bit               ev;
        int               free;
        logic [TAG_W-1:0] w;
        if (!rst_n) begin
            mq.delete();
            mpend = 0;
            movf  = 0;
            mc    = 0;
            return;
        end
        roll = (mc >= LAT + 256) && ((mc - LAT) % 256 == 0);
        ev   = edge_detected && enable;
        w    = event_word(mc, raising_edge, subtimes);
        if (mq.size() > 0 && tag_ready) void'(mq.pop_front());
        free = DEPTH - mq.size();
        if (roll || mpend) begin
            if (free >= 1) begin
                mq.push_back(ROLL);
                mpend = 0;
                if (ev) begin
                    if (free >= 2) mq.push_back(w);
                    else if (movf < 65535) movf++;
                end
            end else begin
                mpend = 1;
                if (ev && movf < 65535) movf++;
            end
        end else if (ev) begin
            if (free >= 1) mq.push_back(w);
            else if (movf < 65535) movf++;
        end
        mc++;
    endtask

    task automatic compare();
        chk("tag_valid", 32'(tag_valid), 32'(mq.size() != 0));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("tag_data", 32'(tag_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk("overflow_count", 32'(overflow_count), 32'(movf));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        compare();
    endtask

    task automatic drive(input bit en, input bit ed, input bit pol, input int sub, input bit rdy);
        enable        = en;
        edge_detected = ed;
        raising_edge  = pol;
        subtimes      = BITS'(sub);
        tag_ready     = rdy;
    endtask

    task automatic run_rand(input int until_c);
        while (mc < until_c) begin
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            step();
        end
    endtask

    task automatic run_idle(input int until_c, input bit rdy);
        while (mc < until_c) begin
            drive(1'b1, 1'b0, 1'b0, 0, rdy);
            step();
        end
    endtask

    int               base;
    logic [TAG_W-1:0] first_w;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
        mc = 0; mpend = 0; movf = 0;
        step();
        chk("reset tag_valid", 32'(tag_valid), 32'd0);
        chk("reset tag_data", 32'(tag_data), 32'd0);
        rst_n = 1'b1;

        // Timestamp alignment
        run_idle(10, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 5, 1'b0);
        step();
        chk("align tag_data", 32'(tag_data), 32'h0845);
        chk("align fifo_level", 32'(fifo_level), 32'd1);
        chk("align tag_valid", 32'(tag_valid), 32'd1);

        // Rollover with coincident falling edge
        run_rand(250);
        run_idle(258, 1'b1);
        base = movf;
        drive(1'b1, 1'b1, 1'b0, 2, 1'b1);
        step();
        chk("roll first word", 32'(tag_data), 32'h1000);
        chk("roll level", 32'(fifo_level), 32'd2);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
        step();
        chk("roll second word", 32'(tag_data), 32'h0002);
        chk("roll no drop", 32'(overflow_count), 32'(base));
        step();

        // Backpressure and overflow
        base = movf;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'b0);
            if (i == 0) first_w = event_word(mc, raising_edge, subtimes);
            step();
        end
        chk("bp level", 32'(fifo_level), 32'd4);
        chk("bp overflow", 32'(overflow_count), 32'(base + 2));
        chk("bp head held", 32'(tag_data), 32'(first_w));
        run_idle(mc + 2, 1'b0);
        run_idle(mc + 4, 1'b1);
        chk("bp drained", 32'(fifo_level), 32'd0);

        // Pending rollover with full FIFO
        run_rand(500);
        run_idle(506, 1'b1);
        while (mc < 510) begin
            drive(1'b1, 1'b1, 1'b1, mc % 8, 1'b0);
            step();
        end
        run_idle(515, 1'b0);
        chk("pend full", 32'(fifo_level), 32'd4);
        base = movf;
        while (mc < 518) begin
            drive(1'b1, 1'b1, 1'b0, 3, 1'b0);
            step();
        end
        chk("pend drops", 32'(overflow_count), 32'(base + 3));
        chk("pend level", 32'(fifo_level), 32'd4);
        run_idle(519, 1'b1);
        run_idle(mc + 1, 1'b0);
        run_idle(mc + 3, 1'b1);
        chk("pend marker", 32'(tag_data), 32'h1000);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'b1);
            step();
        end

        // Enable gating across a wrap
        run_rand(760);
        run_idle(766, 1'b1);
        base = movf;
        while (mc < 771) begin
            drive(1'b0, 1'b1, 1'b1, 7, 1'b0);
            step();
        end
        chk("gate level", 32'(fifo_level), 32'd1);
        chk("gate word", 32'(tag_data), 32'h1000);
        chk("gate overflow", 32'(overflow_count), 32'(base));

        // Mid-operation reset
        run_idle(mc + 2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, i, 1'b0);
            step();
        end
        chk("pre-reset level", 32'(fifo_level), 32'd3);
        rst_n = 1'b0;
        step();
        chk("rst tag_valid", 32'(tag_valid), 32'd0);
        chk("rst fifo_level", 32'(fifo_level), 32'd0);
        chk("rst overflow", 32'(overflow_count), 32'd0);
        rst_n = 1'b1;
        run_idle(10, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 5, 1'b0);
        step();
        chk("restart stamp", 32'(tag_data), 32'h0845);
        run_idle(mc + 1, 1'b1);
        run_idle(LAT + 255, 1'b0);
        chk("no spurious roll", 32'(fifo_level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tagger_tag_packer.md
Name: tagger_tag_packer

Overview:
- Sits directly downstream of one channel's BCD converter.
- Combines the converter's per-clock fine result (subtimes, raising_edge, edge_detected) with a free-running coarse counter to form complete time-tag words.
- Emits rollover markers on coarse-counter wrap so host software can extend time.
- Buffers tags in a small FIFO with a valid/ready output and counts dropped events.

Parameters:
- BITS, 3: fine-time width; matches the converter's subtimes width (2^BITS samples per clk).
- COARSE_BITS, 24: coarse counter width.
- CONV_LATENCY, 2: converter output latency in clk cycles, ≥1; used to align the coarse count.
- FIFO_AW, 4: FIFO address width; depth = 2^FIFO_AW.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  1 = capture events; 0 = ignore events; counter and rollovers unaffected.
- edge_detected  in  1  converter: an edge occurred in this sample block.
- raising_edge  in  1  converter: polarity of the newest edge.
- subtimes  in  BITS  converter: position of the newest edge.
- tag_data  out  TAG_W = 2+COARSE_BITS+BITS  FIFO head word.
- tag_valid  out  1  tag_data holds a valid word.
- tag_ready  in  1  consumer accepts the word when tag_valid && tag_ready.
- fifo_level  out  FIFO_AW+1  number of stored words, including the head.
- overflow_count  out  16  dropped events; saturates at 0xFFFF.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - counter=0, alignment delay line all 0, FIFO empty.
  - tag_valid=0, tag_data=0, fifo_level=0, overflow_count=0, pending_rollover=0.
  - Reset mid-operation discards all stored tags.
- Coarse counter: +1 every clk, wraps modulo 2^COARSE_BITS.
- Alignment: aligned = counter passed through a CONV_LATENCY-stage register delay line (reset 0). aligned is the coarse value stamped onto the converter outputs of the same cycle.
- Event word: {1'b0, raising_edge, aligned, subtimes}. Generated when edge_detected && enable.
- Rollover word: {1'b1, 1'b0, COARSE_BITS'0, BITS'0}.
  - Generated in the cycle aligned==0 and the previous aligned was all-ones.
  - No rollover at reset release, because the delay line starts at 0 rather than wrapping.
- Ordering: when a rollover and an event occur in the same cycle, the rollover is written first, then the event. The write port accepts up to 2 words/cycle.
- Space check uses free = depth − fifo_level, evaluated with this cycle's pop. Simultaneous push and pop at full is allowed.
- pending_rollover state (IDLE / PENDING):
  - A rollover that cannot be written (free=0) sets PENDING.
  - While PENDING, every event is dropped and counted, so no post-wrap event precedes the marker.
  - When free ≥ 1, the rollover is written and the state returns to IDLE. An event arriving in that same cycle is also written if free ≥ 2; otherwise it is dropped.
- Rollover + event with free=1: the rollover is written and the event is dropped (overflow_count+1).
- Event with free=0: the event is dropped; overflow_count+1, saturating.
- Output handshake:
  - Show-ahead FIFO: tag_valid=1 iff level>0.
  - tag_data stable while tag_valid && !tag_ready.
  - Pop on tag_valid && tag_ready.
- Latency: an event at cycle N into an empty FIFO gives tag_valid=1 with its word at cycle N+1.
- Rollovers are never dropped; at most one can be pending. A second wrap needs 2^COARSE_BITS cycles, far longer than any FIFO drain.

Test Plan:
1. Timestamp alignment. BITS=3, COARSE_BITS=8, CONV_LATENCY=2; release reset; at cycle 10 (counter=10) drive edge_detected=1, raising_edge=1, subtimes=5 -> cycle 11: tag_valid=1, tag_data=0x0845 (type 0, pol 1, coarse 8, sub 5), fifo_level=1.
2. Rollover with coincident event. Same config, tag_ready=1; at the cycle aligned first returns to 0, drive falling edge, subtimes=2 -> consecutive words 0x1000 then 0x0002; overflow_count stays 0.
3. Backpressure and overflow. FIFO_AW=2, tag_ready=0; 6 consecutive events -> fifo_level=4, overflow_count=2. tag_data holds the first event unchanged for all cycles; the first 4 words are read out in order once tag_ready=1.
4. Pending rollover. FIFO full, tag_ready=0 when a wrap occurs; 3 more events -> overflow_count+3, no write. Pulse tag_ready for one cycle -> next write is 0x1000; subsequent events are stored normally.
5. Enable gating. enable=0, 5 events plus one wrap -> only 0x1000 stored; overflow_count=0.
6. Mid-operation reset. FIFO with 3 words, overflow_count=7; rst_n=0 for one cycle -> tag_valid=0, fifo_level=0, overflow_count=0, counter restarts at 0, no spurious rollover over the following 255 cycles.
